// File: rtl/find_multi_blobs.sv
// Groups foreground pixels of a raster stream into proximity-merged bounding boxes
// and publishes the compacted blob centres once per frame, on the VGA_VS fall.
module find_multi_blobs #(
  parameter int MAX_POINTS = 8,
  parameter int CNT_W      = 16,
  parameter int MERGE_DIST = 8,
  parameter int MIN_PIXELS = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        VGA_HS,
  input  logic                        VGA_VS,
  input  logic                        BINARY_FLAG,
  input  logic [CNT_W-1:0]            H_CNT,
  input  logic [CNT_W-1:0]            V_CNT,
  output logic [MAX_POINTS*CNT_W-1:0] o_POINTS_H,
  output logic [MAX_POINTS*CNT_W-1:0] o_POINTS_V,
  output logic [MAX_POINTS-1:0]       o_POINTS_LIST,
  output logic [CNT_W-1:0]            o_POINTS_NUM,
  output logic                        o_OVERFLOW,
  output logic                        o_FRAME_DONE
);

  localparam logic [CNT_W:0]   MARGIN  = (CNT_W+1)'(MERGE_DIST);
  localparam logic [CNT_W:0]   SAT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_POINTS-1:0] used_q, used_d;
  logic [CNT_W-1:0] min_h_q [MAX_POINTS];
  logic [CNT_W-1:0] min_h_d [MAX_POINTS];
  logic [CNT_W-1:0] max_h_q [MAX_POINTS];
  logic [CNT_W-1:0] max_h_d [MAX_POINTS];
  logic [CNT_W-1:0] min_v_q [MAX_POINTS];
  logic [CNT_W-1:0] min_v_d [MAX_POINTS];
  logic [CNT_W-1:0] max_v_q [MAX_POINTS];
  logic [CNT_W-1:0] max_v_d [MAX_POINTS];
  logic [CNT_W-1:0] pix_cnt_q [MAX_POINTS];
  logic [CNT_W-1:0] pix_cnt_d [MAX_POINTS];
  logic ovf_q, ovf_d;
  logic vs_prev_q, vs_prev_d;

  logic [MAX_POINTS*CNT_W-1:0] pts_h_q, pts_h_d, pts_v_q, pts_v_d;
  logic [MAX_POINTS-1:0]       list_q, list_d;
  logic [CNT_W-1:0]            num_q, num_d;
  logic                        ovf_out_q, ovf_out_d;
  logic                        done_q, done_d;

  logic                  pix;
  logic                  frame_end;
  logic [MAX_POINTS-1:0] hit;
  logic                  taken;
  int unsigned           n;

  // Window test at CNT_W+1 bits so the margin saturates instead of wrapping.
  function automatic logic in_range(input logic [CNT_W-1:0] p, lo, hi);
    logic [CNT_W:0] l;
    logic [CNT_W:0] h;
    l = ({1'b0, lo} >= MARGIN) ? ({1'b0, lo} - MARGIN) : '0;
    h = {1'b0, hi} + MARGIN;
    if (h > SAT_MAX) h = SAT_MAX;
    return ({1'b0, p} >= l) && ({1'b0, p} <= h);
  endfunction

  function automatic logic [CNT_W-1:0] centre(input logic [CNT_W-1:0] lo, hi);
    logic [CNT_W:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[CNT_W:1];
  endfunction

  assign pix       = VGA_VS & VGA_HS & BINARY_FLAG;
  assign frame_end = vs_prev_q & ~VGA_VS;

  always_comb begin
    hit = '0;
    for (int i = 0; i < MAX_POINTS; i++) begin
      hit[i] = used_q[i] && in_range(H_CNT, min_h_q[i], max_h_q[i])
                         && in_range(V_CNT, min_v_q[i], max_v_q[i]);
    end
  end

  always_comb begin
    used_d    = used_q;
    min_h_d   = min_h_q;
    max_h_d   = max_h_q;
    min_v_d   = min_v_q;
    max_v_d   = max_v_q;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    vs_prev_d = VGA_VS;
    pts_h_d   = pts_h_q;
    pts_v_d   = pts_v_q;
    list_d    = list_q;
    num_d     = num_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    taken     = 1'b0;
    n         = 0;

    if (pix) begin
      // Lowest-index matching slot absorbs; otherwise lowest free slot allocates.
      for (int i = 0; i < MAX_POINTS; i++) begin
        if (!taken && hit[i]) begin
          taken = 1'b1;
          if (H_CNT < min_h_q[i]) min_h_d[i] = H_CNT;
          if (H_CNT > max_h_q[i]) max_h_d[i] = H_CNT;
          if (V_CNT < min_v_q[i]) min_v_d[i] = V_CNT;
          if (V_CNT > max_v_q[i]) max_v_d[i] = V_CNT;
          if (pix_cnt_q[i] != CNT_MAX) pix_cnt_d[i] = pix_cnt_q[i] + 1'b1;
        end
      end
      for (int i = 0; i < MAX_POINTS; i++) begin
        if (!taken && !used_q[i]) begin
          taken        = 1'b1;
          used_d[i]    = 1'b1;
          min_h_d[i]   = H_CNT;
          max_h_d[i]   = H_CNT;
          min_v_d[i]   = V_CNT;
          max_v_d[i]   = V_CNT;
          pix_cnt_d[i] = CNT_W'(1);
        end
      end
      if (!taken) ovf_d = 1'b1;
    end

    if (frame_end) begin
      pts_h_d = '0;
      pts_v_d = '0;
      list_d  = '0;
      for (int i = 0; i < MAX_POINTS; i++) begin
        if (used_q[i] && (pix_cnt_q[i] >= MIN_CNT)) begin
          pts_h_d[n*CNT_W +: CNT_W] = centre(min_h_q[i], max_h_q[i]);
          pts_v_d[n*CNT_W +: CNT_W] = centre(min_v_q[i], max_v_q[i]);
          list_d[n] = 1'b1;
          n = n + 1;
        end
        min_h_d[i]   = '0;
        max_h_d[i]   = '0;
        min_v_d[i]   = '0;
        max_v_d[i]   = '0;
        pix_cnt_d[i] = '0;
      end
      num_d     = CNT_W'(n);
      ovf_out_d = ovf_q;
      used_d    = '0;
      ovf_d     = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      used_q    <= '0;
      ovf_q     <= 1'b0;
      vs_prev_q <= 1'b0;
      pts_h_q   <= '0;
      pts_v_q   <= '0;
      list_q    <= '0;
      num_q     <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < MAX_POINTS; i++) begin
        min_h_q[i]   <= '0;
        max_h_q[i]   <= '0;
        min_v_q[i]   <= '0;
        max_v_q[i]   <= '0;
        pix_cnt_q[i] <= '0;
      end
    end else begin
      used_q    <= used_d;
      ovf_q     <= ovf_d;
      vs_prev_q <= vs_prev_d;
      pts_h_q   <= pts_h_d;
      pts_v_q   <= pts_v_d;
      list_q    <= list_d;
      num_q     <= num_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
      for (int i = 0; i < MAX_POINTS; i++) begin
        min_h_q[i]   <= min_h_d[i];
        max_h_q[i]   <= max_h_d[i];
        min_v_q[i]   <= min_v_d[i];
        max_v_q[i]   <= max_v_d[i];
        pix_cnt_q[i] <= pix_cnt_d[i];
      end
    end
  end

  assign o_POINTS_H    = pts_h_q;
  assign o_POINTS_V    = pts_v_q;
  assign o_POINTS_LIST = list_q;
  assign o_POINTS_NUM  = num_q;
  assign o_OVERFLOW    = ovf_out_q;
  assign o_FRAME_DONE  = done_q;

endmodule

// File: tb/tb_find_multi_blobs.sv
// Directed frame-level bench for find_multi_blobs: a default instance and a
// two-slot instance share the pixel stream; rows without foreground take one clock.
module tb_find_multi_blobs;
  localparam int CW = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N, VGA_HS, VGA_VS, BINARY_FLAG;
  logic [CW-1:0] H_CNT, V_CNT;

  logic [8*CW-1:0] a_h, a_v;
  logic [7:0]      a_list;
  logic [CW-1:0]   a_num;
  logic            a_ovf, a_done;
  logic [2*CW-1:0] b_h, b_v;
  logic [1:0]      b_list;
  logic [CW-1:0]   b_num;
  logic            b_ovf, b_done;

  find_multi_blobs #(.MAX_POINTS(8), .CNT_W(CW), .MERGE_DIST(8), .MIN_PIXELS(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .BINARY_FLAG(BINARY_FLAG),
    .H_CNT(H_CNT), .V_CNT(V_CNT), .o_POINTS_H(a_h), .o_POINTS_V(a_v),
    .o_POINTS_LIST(a_list), .o_POINTS_NUM(a_num), .o_OVERFLOW(a_ovf), .o_FRAME_DONE(a_done));

  find_multi_blobs #(.MAX_POINTS(2), .CNT_W(CW), .MERGE_DIST(8), .MIN_PIXELS(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .BINARY_FLAG(BINARY_FLAG),
    .H_CNT(H_CNT), .V_CNT(V_CNT), .o_POINTS_H(b_h), .o_POINTS_V(b_v),
    .o_POINTS_LIST(b_list), .o_POINTS_NUM(b_num), .o_OVERFLOW(b_ovf), .o_FRAME_DONE(b_done));

  int checks = 0;
  int errors = 0;
  int stray;
  logic [CW-1:0] exp_q[$];

  int rx0[4], ry0[4], rx1[4], ry1[4];
  int nrect;

  typedef struct packed {
    logic            sel;
    logic [15:0]     w, h;
    logic [3:0]      nr;
    logic [3:0][15:0] x0, y0, x1, y1;
    logic [3:0]      n;
    logic            ovf;
    logic [3:0][15:0] eh, ev;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t rect(input vec_t v, input int j, x0, y0, x1, y1);
    v.x0[j] = 16'(x0); v.y0[j] = 16'(y0); v.x1[j] = 16'(x1); v.y1[j] = 16'(y1);
    v.nr = 4'(j + 1);
    return v;
  endfunction

  function automatic vec_t ctr(input vec_t v, input int j, x, y);
    v.eh[j] = 16'(x); v.ev[j] = 16'(y);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit is_fg(input int x, input int y);
    for (int i = 0; i < nrect; i++)
      if (x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit row_fg(input int y);
    for (int i = 0; i < nrect; i++)
      if (y >= ry0[i] && y <= ry1[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit vs, input bit hs, input bit fg, input int x, input int y);
    @(negedge CLK);
    if (a_done || b_done) stray++;
    VGA_VS = vs; VGA_HS = hs; BINARY_FLAG = fg;
    H_CNT = CW'(x); V_CNT = CW'(y);
  endtask

  // Scans a frame, optionally pulsing reset for five rows from rst_row, then drops VS
  // and returns on the negedge after the frame-end edge.
  task automatic run_frame(input string name, input int w, input int h, input int rst_row);
    stray = 0;
    for (int y = 0; y < h; y++) begin
      if (rst_row >= 0 && y == rst_row) begin
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check({name, "_rst_num"}, 64'(a_num), 0);
        check({name, "_rst_list"}, 64'(a_list), 0);
        check({name, "_rst_h"}, 64'(|a_h), 0);
        check({name, "_rst_v"}, 64'(|a_v), 0);
        check({name, "_rst_ovf"}, 64'(a_ovf), 0);
      end
      if (rst_row >= 0 && y == rst_row + 5) RST_N = 1'b1;
      if (row_fg(y))
        for (int x = 0; x < w; x++) drive(1'b1, 1'b1, is_fg(x, y), x, y);
      drive(1'b1, 1'b0, 1'b0, 0, y);
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    check({name, "_no_early_done"}, 64'(stray), 0);
    @(negedge CLK);
  endtask

  task automatic check_out(input string name, input bit sel, input int n, input bit ovf);
    logic [8*CW-1:0] gh, gv;
    logic [7:0]      gl;
    logic [CW-1:0]   gn, eh, ev;
    logic            go, gd;
    int              slots;
    gh = sel ? {{(6*CW){1'b0}}, b_h} : a_h;
    gv = sel ? {{(6*CW){1'b0}}, b_v} : a_v;
    gl = sel ? {6'b0, b_list} : a_list;
    gn = sel ? b_num : a_num;
    go = sel ? b_ovf : a_ovf;
    gd = sel ? b_done : a_done;
    slots = sel ? 2 : 8;
    check({name, "_done"}, 64'(gd), 1);
    check({name, "_num"}, 64'(gn), 64'(n));
    check({name, "_list"}, 64'(gl), 64'((1 << n) - 1));
    check({name, "_ovf"}, 64'(go), 64'(ovf));
    for (int k = 0; k < slots; k++) begin
      eh = '0; ev = '0;
      if (k < n && exp_q.size() >= 2) begin
        eh = exp_q.pop_front();
        ev = exp_q.pop_front();
      end
      check($sformatf("%s_entry%0d", name, k), {32'(gh[k*CW +: CW]), 32'(gv[k*CW +: CW])},
            {32'(eh), 32'(ev)});
    end
    exp_q.delete();
    @(negedge CLK);
    check({name, "_done_drop"}, 64'(sel ? b_done : a_done), 0);
  endtask

  task automatic load_rects(input vec_t v);
    nrect = int'(v.nr);
    for (int j = 0; j < 4; j++) begin
      rx0[j] = int'(v.x0[j]); ry0[j] = int'(v.y0[j]);
      rx1[j] = int'(v.x1[j]); ry1[j] = int'(v.y1[j]);
    end
  endtask

  initial begin
    RST_N = 1'b0; VGA_HS = 1'b0; VGA_VS = 1'b0; BINARY_FLAG = 1'b0;
    H_CNT = '0; V_CNT = '0; nrect = 0;

    for (int i = 0; i < 9; i++) vecs[i] = '0;
    // single 3x3 blob in a 200x100 frame
    vecs[0].w = 200; vecs[0].h = 100; vecs[0].n = 1;
    vecs[0] = rect(vecs[0], 0, 50, 20, 52, 22);
    vecs[0] = ctr(vecs[0], 0, 51, 21);
    // four blobs, repeated twice
    vecs[1].w = 160; vecs[1].h = 90; vecs[1].n = 4;
    vecs[1] = rect(vecs[1], 0, 19, 9, 21, 11);
    vecs[1] = rect(vecs[1], 1, 99, 9, 101, 11);
    vecs[1] = rect(vecs[1], 2, 19, 79, 21, 81);
    vecs[1] = rect(vecs[1], 3, 149, 79, 151, 81);
    vecs[1] = ctr(vecs[1], 0, 20, 10);
    vecs[1] = ctr(vecs[1], 1, 100, 10);
    vecs[1] = ctr(vecs[1], 2, 20, 80);
    vecs[1] = ctr(vecs[1], 3, 150, 80);
    vecs[2] = vecs[1];
    // 5 px gap merges into one box x 10..20
    vecs[3].w = 64; vecs[3].h = 32; vecs[3].n = 1;
    vecs[3] = rect(vecs[3], 0, 10, 10, 12, 12);
    vecs[3] = rect(vecs[3], 1, 18, 10, 20, 12);
    vecs[3] = ctr(vecs[3], 0, 15, 11);
    // 20 px gap stays separate
    vecs[4].w = 64; vecs[4].h = 32; vecs[4].n = 2;
    vecs[4] = rect(vecs[4], 0, 10, 10, 12, 12);
    vecs[4] = rect(vecs[4], 1, 33, 10, 35, 12);
    vecs[4] = ctr(vecs[4], 0, 11, 11);
    vecs[4] = ctr(vecs[4], 1, 34, 11);
    // isolated pixel below MIN_PIXELS
    vecs[5].w = 64; vecs[5].h = 32; vecs[5].n = 1;
    vecs[5] = rect(vecs[5], 0, 5, 5, 5, 5);
    vecs[5] = rect(vecs[5], 1, 30, 20, 32, 22);
    vecs[5] = ctr(vecs[5], 0, 31, 21);
    // origin corner, no wrap of the lower margin
    vecs[6].w = 64; vecs[6].h = 32; vecs[6].n = 1;
    vecs[6] = rect(vecs[6], 0, 0, 0, 2, 2);
    vecs[6] = ctr(vecs[6], 0, 1, 1);
    // two-slot instance: three blobs overflow, then an empty frame
    vecs[7].sel = 1'b1; vecs[7].w = 64; vecs[7].h = 16; vecs[7].n = 2; vecs[7].ovf = 1'b1;
    vecs[7] = rect(vecs[7], 0, 10, 5, 12, 7);
    vecs[7] = rect(vecs[7], 1, 30, 5, 32, 7);
    vecs[7] = rect(vecs[7], 2, 50, 5, 52, 7);
    vecs[7] = ctr(vecs[7], 0, 11, 6);
    vecs[7] = ctr(vecs[7], 1, 31, 6);
    vecs[8].sel = 1'b1; vecs[8].w = 64; vecs[8].h = 16; vecs[8].n = 0;

    repeat (3) @(negedge CLK);
    check("reset_a_num", 64'(a_num), 0);
    check("reset_a_list", 64'(a_list), 0);
    check("reset_a_hv", 64'(|{a_h, a_v}), 0);
    check("reset_a_ovf_done", 64'({a_ovf, a_done}), 0);
    check("reset_b_all", 64'(|{b_h, b_v, b_list, b_num, b_ovf, b_done}), 0);
    RST_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      load_rects(vecs[i]);
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        exp_q.push_back(vecs[i].eh[j]);
        exp_q.push_back(vecs[i].ev[j]);
      end
      run_frame($sformatf("vec%0d", i), int'(vecs[i].w), int'(vecs[i].h), -1);
      check_out($sformatf("vec%0d", i), vecs[i].sel, int'(vecs[i].n), vecs[i].ovf);
    end

    // republish something nonzero, then reset mid-frame at row 50
    load_rects(vecs[0]);
    exp_q.push_back(16'd51); exp_q.push_back(16'd21);
    run_frame("warm", 200, 100, -1);
    check_out("warm", 1'b0, 1, 1'b0);
    nrect = 2;
    rx0[0] = 20; ry0[0] = 10; rx1[0] = 22; ry1[0] = 12;
    rx0[1] = 20; ry0[1] = 70; rx1[1] = 22; ry1[1] = 72;
    exp_q.push_back(16'd21); exp_q.push_back(16'd71);
    run_frame("midrst", 64, 100, 50);
    check_out("midrst", 1'b0, 1, 1'b0);

    // VS high for one clock with a lone pixel: frame publishes, nothing qualifies
    stray = 0;
    drive(1'b1, 1'b1, 1'b1, 5, 5);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge CLK);
    check_out("vs_one", 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/find_multi_blobs.md
# find_multi_blobs

Parametrised successor to the team's multi-point finder. It watches the thresholded pixel stream from the D8M/VGA path, with `BINARY_FLAG` qualified by `VGA_HS`/`VGA_VS` and positioned by `H_CNT`/`V_CNT`. It groups foreground pixels into up to `MAX_POINTS` blobs using proximity-merged bounding boxes, and publishes blob centres once per frame. Downstream motion-capture logic reads the latched centre set, the valid mask and the count after each frame-done pulse.

## Interface
Parameters:
- `MAX_POINTS`, 8: number of blob slots (1..16).
- `CNT_W`, 16: width of `H_CNT`/`V_CNT`, coordinates and pixel counters.
- `MERGE_DIST`, 8: pixel margin added around each slot's box when matching.
- `MIN_PIXELS`, 4: minimum pixel count for a slot to be published.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `VGA_HS`  in  1  line-active qualifier, high during visible pixels.
- `VGA_VS`  in  1  frame-active qualifier, high during visible lines.
- `BINARY_FLAG`  in  1  foreground pixel.
- `H_CNT`  in  CNT_W  current pixel x.
- `V_CNT`  in  CNT_W  current pixel y.
- `o_POINTS_H`  out  MAX_POINTS*CNT_W  compacted centre x; entry k is at bits [k*CNT_W +: CNT_W].
- `o_POINTS_V`  out  MAX_POINTS*CNT_W  compacted centre y, same packing.
- `o_POINTS_LIST`  out  MAX_POINTS  valid mask; bit k set means entry k holds a centre.
- `o_POINTS_NUM`  out  CNT_W  number of published centres.
- `o_OVERFLOW`  out  1  the last frame had a pixel that needed a new slot when none was free.
- `o_FRAME_DONE`  out  1  one-cycle pulse when outputs update.

## Operation
- Per-slot state:
  - `used` flag, 1 bit.
  - Bounding box `min_h`, `max_h`, `min_v`, `max_v`, each CNT_W.
  - `pix_cnt`, CNT_W, saturating at all-ones.
- Accepted pixel: `VGA_VS & VGA_HS & BINARY_FLAG` sampled high on a rising `CLK`.
- Match test for a used slot:
  - `H_CNT` lies in [`min_h`−`MERGE_DIST`, `max_h`+`MERGE_DIST`] and `V_CNT` lies in [`min_v`−`MERGE_DIST`, `max_v`+`MERGE_DIST`].
  - Lower bounds saturate at 0; upper bounds saturate at 2^CNT_W−1. No wrap.
- Accepted pixel with one or more matching slots:
  - Only the lowest-index matching slot absorbs it: box extended, `pix_cnt`+1.
  - Slots are never merged with each other.
- Accepted pixel with no match:
  - The lowest-index unused slot is allocated with box = (H,H,V,V) and `pix_cnt`=1.
  - If no unused slot exists, the pixel is dropped and the internal overflow bit is set.
- Frame end is the clock on which `VGA_VS` is sampled 0 after being sampled 1 on the previous clock. On that clock:
  - A slot qualifies when `used` and `pix_cnt` ≥ `MIN_PIXELS`.
  - Qualifying slots are compacted in ascending slot order into entries 0..n−1, with centre = (min+max)>>1 computed at CNT_W+1 bits and truncated.
  - Unused entries are zero. `o_POINTS_LIST` = (1<<n)−1, `o_POINTS_NUM` = n.
  - `o_OVERFLOW` takes the internal overflow bit.
  - All slots and the internal overflow bit are cleared.
  - `o_FRAME_DONE` = 1.
- Between frame ends the outputs hold their last published values.
- Pixels arriving while `VGA_VS`=0 are ignored, so frame end never coincides with accumulation.

## Timing
- Reset values: all outputs 0. All slots unused, overflow clear, previous-VS register 0.
- Pixel absorb/allocate takes effect on the same rising edge the pixel is sampled. The next pixel, one cycle later, sees the updated box; this gives a throughput of one pixel per clock.
- Latency from the last frame-active clock to outputs: outputs and `o_FRAME_DONE` become visible after the first edge that samples `VGA_VS`=0. `o_FRAME_DONE` deasserts on the following edge.
- Reset asserted mid-frame: all state clears immediately and no `o_FRAME_DONE` fires. If reset is released while `VGA_VS`=1, the previous-VS register loads 1 on the first edge. Accumulation then runs over the remaining pixels, and that partial frame publishes at its `VGA_VS` fall.
- `VGA_VS` high for exactly one clock: the frame is processed and published normally.

## Test plan
- 200x100 frame with a single 3x3 blob at x 50..52, y 20..22 -> after VS falls: NUM=1, LIST=0x01, entry 0 = (51,21), FRAME_DONE high for one cycle.
- Four 3x3 blobs centred at (20,10), (100,10), (20,80), (150,80); second identical frame -> both frames give NUM=4, entries in raster first-hit order, no OVERFLOW.
- Two 3x3 blobs whose boxes are 5 px apart with MERGE_DIST=8 -> one entry, centre at the midpoint of the combined box. The same blobs 20 px apart -> two entries.
- MAX_POINTS=2 with three separated blobs -> NUM=2 (first two in raster order), OVERFLOW=1. A following empty frame -> NUM=0, LIST=0, OVERFLOW=0.
- Single isolated pixel plus one 3x3 blob, MIN_PIXELS=4 -> NUM=1, only the 3x3 centre published. Blob at x=0..2, y=0..2 -> centre (1,1), no wrap.
- Assert `RST_N` at row 50 of a frame -> outputs 0 immediately. Release mid-frame with a blob below row 60 -> only that blob is reported at VS fall.
